rf68000_ring_server: RTL and testbench



---
 rtl/nic_pkg.sv | 35 +++
 rtl/rf68000_ring_server_if.sv | 31 +++
 rtl/rf68000_ring_fifo.sv | 50 +++++
 rtl/rf68000_ring_server.sv | 199 +++++++++++++++++++
 tb/tb_rf68000_ring_server.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nic_pkg.sv
// Packet ring shared types for the rf68000 SoC.
// Packet layout, packet type codes and well-known node IDs.
package nic_pkg;

    localparam logic [5:0] NIC_SERVER_ID = 6'd62;
    localparam logic [5:0] NIC_BCAST_ID  = 6'd63;

    typedef enum logic [3:0] {
        PT_NULL  = 4'd0,
        PT_READ  = 4'd1,
        PT_WRITE = 4'd2,
        PT_AREAD = 4'd3,
        PT_ACK   = 4'd4,
        PT_AACK  = 4'd5,
        PT_ERR   = 4'd6,
        PT_VPA   = 4'd7,
        PT_IRQ   = 4'd8
    } pkt_type_t;

    typedef struct packed {
        logic [5:0]  did;
        logic [5:0]  sid;
        logic [5:0]  age;
        logic        ack;
        pkt_type_t   typ;
        logic [7:0]  asid;
        logic        mmus;
        logic        ios;
        logic        iops;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } packet_t;

endpackage

// File: rtl/rf68000_ring_server_if.sv
// Bus master port of the ring server.
// Master drives strobes/attributes; slave returns terminations and data.
interface rf68000_ring_server_if;
    logic [5:0]  core;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [7:0]  asid;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic        mmus;
    logic        ios;
    logic        iops;
    logic        ack;
    logic        err;
    logic        vpa;
    logic [31:0] rdat;

    modport master (
        output core, cyc, stb, we, sel, asid, adr, wdat,
        output mmus, ios, iops,
        input  ack, err, vpa, rdat
    );

    modport slave (
        input  core, cyc, stb, we, sel, asid, adr, wdat,
        input  mmus, ios, iops,
        output ack, err, vpa, rdat
    );
endinterface

// File: rtl/rf68000_ring_fifo.sv
// Request queue for the ring server.
// First-word-fall-through packet FIFO with registered pointers.
module rf68000_ring_fifo
    import nic_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    push,
    input  logic    pop,
    input  packet_t din,
    output packet_t dout,
    output logic    full,
    output logic    empty
);
    localparam int AW = $clog2(DEPTH);

    packet_t        mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    cnt;
    logic           do_push;
    logic           do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage write; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      cnt <= cnt + 1'b1;
            else if (do_pop && !do_push) cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/rf68000_ring_server.sv
// Ring root / global resource responder at node 62.
// Captures requests, runs one bus cycle each, returns a response packet.
module rf68000_ring_server
    import nic_pkg::*;
#(
    parameter logic [5:0] ID         = NIC_SERVER_ID,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [5:0] MAX_AGE    = 6'd63,
    parameter bit         SYNC_WRITE = 1'b1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  packet_t        packet_i,
    output packet_t        packet_o,
    input  packet_t        rpacket_i,
    output packet_t        rpacket_o,
    rf68000_ring_server_if.master m,
    output logic           busy_o,
    output logic [15:0]    drop_cnt_o
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUS  = 1'b1;

    logic [0:0]  state;
    packet_t     req;
    packet_t     resp;
    logic        resp_valid;
    logic [10:0] tmo;
    packet_t     fifo_dout;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        term;
    logic        load_resp;
    pkt_type_t   rtyp;
    packet_t     pkt_n;
    packet_t     rpk_n;
    logic        drop_req;
    logic        drop_rsp;
    logic        inject;
    logic        is_req;
    logic [16:0] drop_sum;

    rf68000_ring_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .pop   (pop),
        .din   (packet_i),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    assign is_req = (packet_i.typ == PT_READ) ||
                    (packet_i.typ == PT_AREAD) ||
                    (packet_i.typ == PT_WRITE);
    assign pop    = (state == ST_IDLE) && !empty && !resp_valid;
    assign term   = m.ack || m.err || m.vpa || tmo[10];
    assign load_resp = (req.typ != PT_WRITE) || SYNC_WRITE;
    assign busy_o = !empty || (state == ST_BUS) || resp_valid;

    // Request ring: age, capture, discard and drop stale packets.
    always_comb begin
        pkt_n    = packet_i;
        push     = 1'b0;
        drop_req = 1'b0;
        if (packet_i.did != 6'd0) pkt_n.age = packet_i.age + 6'd1;
        if (packet_i.did == ID && is_req && !full) begin
            push = 1'b1;
        end
        if (push || (packet_i.did == ID && !is_req)) begin
            pkt_n.did = '0;
            pkt_n.sid = '0;
        end else if (packet_i.did != 6'd0 &&
                     packet_i.age >= MAX_AGE - 6'd1) begin
            pkt_n.did = '0;
            pkt_n.sid = '0;
            drop_req  = 1'b1;
        end
    end

    // Response ring: age, inject pending response into an empty slot.
    always_comb begin
        rpk_n    = rpacket_i;
        inject   = 1'b0;
        drop_rsp = 1'b0;
        if (rpacket_i.did != 6'd0) rpk_n.age = rpacket_i.age + 6'd1;
        if (rpacket_i.did == 6'd0 && resp_valid) begin
            rpk_n  = resp;
            inject = 1'b1;
        end else if (rpacket_i.did != 6'd0 &&
                     rpacket_i.age >= MAX_AGE - 6'd1) begin
            rpk_n.did = '0;
            rpk_n.sid = '0;
            drop_rsp  = 1'b1;
        end
    end

    // Termination priority: ack, then err, then vpa, then timeout.
    always_comb begin
        rtyp = PT_ERR;
        if (m.ack)      rtyp = (req.typ == PT_AREAD) ? PT_AACK : PT_ACK;
        else if (m.err) rtyp = PT_ERR;
        else if (m.vpa) rtyp = PT_VPA;
        drop_sum = {1'b0, drop_cnt_o} + {16'd0, drop_req} +
                   {16'd0, drop_rsp};
    end

    // Ring registers and saturating drop counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            packet_o   <= '0;
            rpacket_o  <= '0;
            drop_cnt_o <= '0;
        end else begin
            packet_o   <= pkt_n;
            rpacket_o  <= rpk_n;
            drop_cnt_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    // Bus FSM, timeout counter and response holding register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= ST_IDLE;
            req        <= '0;
            resp       <= '0;
            resp_valid <= 1'b0;
            tmo        <= '0;
            m.core     <= '0;
            m.cyc      <= 1'b0;
            m.stb      <= 1'b0;
            m.we       <= 1'b0;
            m.sel      <= '0;
            m.asid     <= '0;
            m.adr      <= '0;
            m.wdat     <= '0;
            m.mmus     <= 1'b0;
            m.ios      <= 1'b0;
            m.iops     <= 1'b0;
        end else begin
            if (inject) resp_valid <= 1'b0;
            if (!m.stb || term) tmo <= '0;
            else                tmo <= tmo + 11'd1;
            unique case (state)
                ST_IDLE: begin
                    if (pop) begin
                        req    <= fifo_dout;
                        m.core <= fifo_dout.sid;
                        m.cyc  <= 1'b1;
                        m.stb  <= 1'b1;
                        m.we   <= (fifo_dout.typ == PT_WRITE);
                        m.sel  <= (fifo_dout.typ == PT_WRITE) ?
                                  fifo_dout.sel : 4'hF;
                        m.asid <= fifo_dout.asid;
                        m.adr  <= fifo_dout.adr;
                        m.wdat <= fifo_dout.dat;
                        m.mmus <= fifo_dout.mmus;
                        m.ios  <= fifo_dout.ios;
                        m.iops <= fifo_dout.iops;
                        state  <= ST_BUS;
                    end
                end
                default: begin
                    if (term) begin
                        m.core <= '0;
                        m.cyc  <= 1'b0;
                        m.stb  <= 1'b0;
                        m.we   <= 1'b0;
                        m.sel  <= '0;
                        m.asid <= '0;
                        m.adr  <= '0;
                        m.wdat <= '0;
                        m.mmus <= 1'b0;
                        m.ios  <= 1'b0;
                        m.iops <= 1'b0;
                        state  <= ST_IDLE;
                        if (load_resp) begin
                            resp_valid <= 1'b1;
                            resp       <= '0;
                            resp.did   <= req.sid;
                            resp.sid   <= ID;
                            resp.ack   <= 1'b1;
                            resp.typ   <= rtyp;
                            resp.asid  <= req.asid;
                            resp.mmus  <= req.mmus;
                            resp.ios   <= req.ios;
                            resp.iops  <= req.iops;
                            resp.adr   <= req.adr;
                            resp.dat   <= m.rdat;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rf68000_ring_server.sv
// Directed bench for rf68000_ring_server.
// Bench plays ring neighbours and bus slave; expectations are hand-derived.
module tb_rf68000_ring_server;
    import nic_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    packet_t     pin, pout, rin, rout;
    packet_t     pin2, pout2, rin2, rout2;
    logic        busy, busy2;
    logic [15:0] dcnt, dcnt2;
    int          checks = 0;
    int          errors = 0;

    rf68000_ring_server_if bi ();
    rf68000_ring_server_if bi2 ();

    rf68000_ring_server #(.SYNC_WRITE(1'b1)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .packet_i(pin), .packet_o(pout),
        .rpacket_i(rin), .rpacket_o(rout),
        .m(bi), .busy_o(busy), .drop_cnt_o(dcnt)
    );

    rf68000_ring_server #(.SYNC_WRITE(1'b0)) u_dut_nw (
        .clk_i(clk_i), .rst_i(rst_i),
        .packet_i(pin2), .packet_o(pout2),
        .rpacket_i(rin2), .rpacket_o(rout2),
        .m(bi2), .busy_o(busy2), .drop_cnt_o(dcnt2)
    );

    always #5 clk_i = ~clk_i;

    function automatic packet_t mk(input logic [5:0] did, input logic [5:0] sid,
                                   input logic [5:0] age, input pkt_type_t typ,
                                   input logic [31:0] adr, input logic [31:0] dat,
                                   input logic [3:0] sel);
        packet_t p;
        p = '0;
        p.did = did; p.sid = sid; p.age = age; p.typ = typ;
        p.adr = adr; p.dat = dat; p.sel = sel; p.asid = 8'h5A;
        return p;
    endfunction

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic send(input packet_t p);
        pin = p;
        tick();
        pin = '0;
    endtask

    task automatic wait_cyc(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (bi.cyc) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic serve_one(input logic [5:0] sid);
        bit ok;
        wait_cyc(10, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL serve_wait sid=%0d: cyc never rose", sid);
            return;
        end
        checks++;
        if (bi.core !== sid) begin
            errors++;
            $display("FAIL serve_core got %0d want %0d", bi.core, sid);
        end
        bi.ack = 1'b1;
        bi.rdat = {26'd0, sid};
        tick();
        bi.ack = 1'b0;
        tick();
        checks++;
        if (rout.did !== sid || rout.typ !== PT_ACK || rout.dat !== {26'd0, sid}) begin
            errors++;
            $display("FAIL serve_resp got did=%0d typ=%0d dat=%h want did=%0d ACK",
                     rout.did, rout.typ, rout.dat, sid);
        end
    endtask

    task automatic test_reset();
        pin = mk(6'd5, 6'd1, 6'd0, PT_READ, 32'h1, 32'h0, 4'h0);
        rin = mk(6'd3, 6'd2, 6'd0, PT_ACK, 32'h1, 32'h0, 4'h0);
        repeat (3) tick();
        checks++;
        if (pout !== '0 || rout !== '0) begin
            errors++;
            $display("FAIL reset_rings got %h / %h want 0", pout, rout);
        end
        checks++;
        if (bi.cyc !== 1'b0 || bi.stb !== 1'b0 || bi.sel !== 4'h0) begin
            errors++;
            $display("FAIL reset_bus cyc=%b stb=%b sel=%h want 0", bi.cyc, bi.stb, bi.sel);
        end
        checks++;
        if (busy !== 1'b0 || dcnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_status busy=%b drop=%0d want 0/0", busy, dcnt);
        end
        pin = '0;
        rin = '0;
        rst_i = 1'b1;
        tick();
    endtask

    task automatic test_ageing();
        pin = mk(6'd5, 6'd1, 6'd62, PT_READ, 32'h0, 32'h0, 4'h0);
        tick();
        checks++;
        if (pout.did !== 6'd0 || dcnt !== 16'd1) begin
            errors++;
            $display("FAIL age_req_drop did=%0d drop=%0d want 0/1", pout.did, dcnt);
        end
        pin = mk(6'd5, 6'd1, 6'd10, PT_READ, 32'h0, 32'h0, 4'h0);
        tick();
        checks++;
        if (pout.did !== 6'd5 || pout.age !== 6'd11) begin
            errors++;
            $display("FAIL age_pass did=%0d age=%0d want 5/11", pout.did, pout.age);
        end
        pin = mk(6'd62, 6'd1, 6'd0, PT_ACK, 32'h0, 32'h0, 4'h0);
        tick();
        checks++;
        if (pout.did !== 6'd0 || dcnt !== 16'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL age_discard did=%0d drop=%0d busy=%b want 0/1/0",
                     pout.did, dcnt, busy);
        end
        pin = '0;
        rin = mk(6'd3, 6'd9, 6'd62, PT_ACK, 32'h0, 32'h0, 4'h0);
        tick();
        rin = '0;
        checks++;
        if (rout.did !== 6'd0 || dcnt !== 16'd2) begin
            errors++;
            $display("FAIL age_rsp_drop did=%0d drop=%0d want 0/2", rout.did, dcnt);
        end
    endtask

    task automatic test_read();
        send(mk(6'd62, 6'd3, 6'd0, PT_READ, 32'h2000_0010, 32'h0, 4'h0));
        checks++;
        if (pout.did !== 6'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL read_capture did=%0d busy=%b want 0/1", pout.did, busy);
        end
        tick();
        checks++;
        if (bi.cyc !== 1'b1 || bi.stb !== 1'b1 || bi.we !== 1'b0 || bi.sel !== 4'hF) begin
            errors++;
            $display("FAIL read_bus cyc=%b stb=%b we=%b sel=%h want 1/1/0/F",
                     bi.cyc, bi.stb, bi.we, bi.sel);
        end
        checks++;
        if (bi.adr !== 32'h2000_0010 || bi.core !== 6'd3 || bi.asid !== 8'h5A) begin
            errors++;
            $display("FAIL read_attr adr=%h core=%0d asid=%h want 20000010/3/5A",
                     bi.adr, bi.core, bi.asid);
        end
        tick();
        tick();
        bi.ack = 1'b1;
        bi.rdat = 32'hDEADBEEF;
        tick();
        bi.ack = 1'b0;
        checks++;
        if (bi.cyc !== 1'b0 || bi.sel !== 4'h0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL read_end cyc=%b sel=%h busy=%b want 0/0/1", bi.cyc, bi.sel, busy);
        end
        tick();
        checks++;
        if (rout.did !== 6'd3 || rout.sid !== 6'd62 || rout.typ !== PT_ACK ||
            rout.ack !== 1'b1 || rout.age !== 6'd0) begin
            errors++;
            $display("FAIL read_resp_hdr did=%0d sid=%0d typ=%0d ack=%b age=%0d want 3/62/ACK/1/0",
                     rout.did, rout.sid, rout.typ, rout.ack, rout.age);
        end
        checks++;
        if (rout.dat !== 32'hDEADBEEF || rout.adr !== 32'h2000_0010) begin
            errors++;
            $display("FAIL read_resp_data dat=%h adr=%h want DEADBEEF/20000010",
                     rout.dat, rout.adr);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL read_idle busy=%b want 0", busy);
        end
    endtask

    task automatic test_write_sync();
        send(mk(6'd62, 6'd7, 6'd0, PT_WRITE, 32'h3000_0000, 32'h1234, 4'h3));
        tick();
        checks++;
        if (bi.we !== 1'b1 || bi.sel !== 4'h3 || bi.wdat !== 32'h1234) begin
            errors++;
            $display("FAIL wr_bus we=%b sel=%h dat=%h want 1/3/1234", bi.we, bi.sel, bi.wdat);
        end
        bi.ack = 1'b1;
        bi.rdat = 32'h0;
        tick();
        bi.ack = 1'b0;
        tick();
        checks++;
        if (rout.did !== 6'd7 || rout.typ !== PT_ACK) begin
            errors++;
            $display("FAIL wr_sync_resp did=%0d typ=%0d want 7/ACK", rout.did, rout.typ);
        end
    endtask

    task automatic test_write_silent();
        int seen;
        seen = 0;
        pin2 = mk(6'd62, 6'd7, 6'd0, PT_WRITE, 32'h3000_0000, 32'h1234, 4'h3);
        tick();
        pin2 = '0;
        tick();
        checks++;
        if (bi2.cyc !== 1'b1 || bi2.we !== 1'b1 || bi2.sel !== 4'h3) begin
            errors++;
            $display("FAIL wr_silent_bus cyc=%b we=%b sel=%h want 1/1/3", bi2.cyc, bi2.we, bi2.sel);
        end
        bi2.ack = 1'b1;
        tick();
        bi2.ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rout2.did !== 6'd0) seen++;
        end
        checks++;
        if (seen !== 0 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL wr_silent_resp slots=%0d busy=%b want 0/0", seen, busy2);
        end
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        send(mk(6'd62, 6'd4, 6'd0, PT_READ, 32'h4000_0000, 32'h0, 4'h0));
        tick();
        while (bi.cyc === 1'b1 && n < 1200) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 1025) begin
            errors++;
            $display("FAIL timeout_len cycles=%0d want 1025", n);
        end
        tick();
        checks++;
        if (rout.did !== 6'd4 || rout.typ !== PT_ERR) begin
            errors++;
            $display("FAIL timeout_resp did=%0d typ=%0d want 4/ERR", rout.did, rout.typ);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        packet_t occ;
        occ = mk(6'd20, 6'd21, 6'd0, PT_ACK, 32'h0, 32'h0, 4'h0);
        send(mk(6'd62, 6'd9, 6'd0, PT_READ, 32'h5000_0000, 32'h0, 4'h0));
        wait_cyc(5, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_first_wait cyc never rose");
        end
        bi.ack = 1'b1;
        bi.rdat = 32'h9;
        rin = occ;
        tick();
        bi.ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pin = mk(6'd62, 6'(10 + i), 6'd0, PT_READ, 32'h6000_0000, 32'h0, 4'h0);
            tick();
            if (i == 3) begin
                checks++;
                if (pout.did !== 6'd0) begin
                    errors++;
                    $display("FAIL bp_fourth did=%0d want 0", pout.did);
                end
            end
            if (i >= 4) begin
                checks++;
                if (pout.did !== 6'd62 || pout.sid !== 6'(10 + i) || pout.age !== 6'd1) begin
                    errors++;
                    $display("FAIL bp_pass did=%0d sid=%0d age=%0d want 62/%0d/1",
                             pout.did, pout.sid, pout.age, 10 + i);
                end
            end
        end
        checks++;
        if (rout.did !== 6'd20 || rout.age !== 6'd1 || bi.cyc !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold did=%0d age=%0d cyc=%b want 20/1/0",
                     rout.did, rout.age, bi.cyc);
        end
        pin = '0;
        rin = '0;
        tick();
        checks++;
        if (rout.did !== 6'd9 || rout.typ !== PT_ACK || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_inject did=%0d typ=%0d busy=%b want 9/ACK/1",
                     rout.did, rout.typ, busy);
        end
        for (int i = 0; i < 4; i++) serve_one(6'(10 + i));
        send(mk(6'd62, 6'd14, 6'd1, PT_READ, 32'h6000_0000, 32'h0, 4'h0));
        serve_one(6'd14);
        send(mk(6'd62, 6'd15, 6'd1, PT_READ, 32'h6000_0000, 32'h0, 4'h0));
        serve_one(6'd15);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        bad = 0;
        send(mk(6'd62, 6'd8, 6'd0, PT_READ, 32'h7000_0000, 32'h0, 4'h0));
        tick();
        checks++;
        if (bi.cyc !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_start cyc=%b want 1", bi.cyc);
        end
        rst_i = 1'b0;
        #1;
        checks++;
        if (bi.cyc !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async cyc=%b busy=%b want 0/0", bi.cyc, busy);
        end
        tick();
        rst_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rout.did !== 6'd0 || bi.cyc !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL rstmid_quiet bad_cycles=%0d want 0", bad);
        end
    endtask

    initial begin
        pin = '0; rin = '0; pin2 = '0; rin2 = '0;
        bi.ack = 1'b0; bi.err = 1'b0; bi.vpa = 1'b0; bi.rdat = '0;
        bi2.ack = 1'b0; bi2.err = 1'b0; bi2.vpa = 1'b0; bi2.rdat = '0;
        test_reset();
        test_ageing();
        test_read();
        test_write_sync();
        test_write_silent();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
